// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and helpers: FSM states, the bubble encoding and
// the fetch address legality check.
package fetch_pkg;

    typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INCR   = 4;

    // An address is bad when it is not word aligned or lies past the last word.
    function automatic logic addr_is_bad(input logic [63:0] addr, input logic [63:0] mem_size);
        return (addr[1:0] != 2'b00) || (addr >= (mem_size << 2));
    endfunction

endpackage

// File: rtl/if_id_register.sv
// Generic valid/instr/pc/pc_plus4 stage register. Flush beats load, and the
// pc fields keep their last values while the entry is empty.
module if_id_register #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    instr_in,
    input  logic [ADDRESS_WIDTH-1:0] pc_in,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_in,
    output logic                     valid,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= instr_in;
            pc       <= pc_in;
            pc_plus4 <= pc_plus4_in;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// hands instructions to decode through the IF/ID register.
module instruction_fetch_unit #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       MEM_SIZE      = 256,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = fetch_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0]    imem_instruction,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    input  logic                     id_ready,
    output logic                     if_id_valid,
    output logic [DATA_WIDTH-1:0]    if_id_instr,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc_plus4,
    output logic                     fetch_fault,
    output logic [ADDRESS_WIDTH-1:0] fault_addr,
    output logic [31:0]              stall_count
);
    import fetch_pkg::*;

    fetch_state_t             state, state_n;
    logic [ADDRESS_WIDTH-1:0] pc, pc_n, pc_inc, fault_addr_n;
    logic                     pc_bad, tgt_bad;
    logic                     load, flush, stall_inc;

    assign pc_inc       = pc + ADDRESS_WIDTH'(PC_INCR);
    assign pc_bad       = addr_is_bad(64'(pc), 64'(MEM_SIZE));
    assign tgt_bad      = addr_is_bad(64'(redirect_target), 64'(MEM_SIZE));
    assign imem_address = pc;
    assign fetch_fault  = (state == FAULT);

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        fault_addr_n = fault_addr;
        load         = 1'b0;
        flush        = 1'b0;
        stall_inc    = 1'b0;
        case (state)
            BOOT: begin
                if (pc_bad) begin
                    state_n      = FAULT;
                    fault_addr_n = pc;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (tgt_bad) begin
                        state_n      = FAULT;
                        fault_addr_n = redirect_target;
                    end else begin
                        pc_n = redirect_target;
                    end
                end else if (pc_bad) begin
                    state_n      = FAULT;
                    fault_addr_n = pc;
                    flush        = 1'b1;
                end else if (!if_id_valid || id_ready) begin
                    load = 1'b1;
                    pc_n = pc_inc;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            FAULT: ;
            default: state_n = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            fault_addr  <= '0;
            stall_count <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            fault_addr <= fault_addr_n;
            // Saturate rather than wrap so long stalls never read as short ones.
            if (stall_inc && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end

    if_id_register #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .NOP_INSTR    (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (flush),
        .instr_in   (imem_instruction),
        .pc_in      (pc),
        .pc_plus4_in(pc_inc),
        .valid      (if_id_valid),
        .instr      (if_id_instr),
        .pc         (if_id_pc),
        .pc_plus4   (if_id_pc_plus4)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, async reset
// sequence and a randomized run against a behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W   = 32'h1000_0000;

    logic        clk, rst_n;
    logic [31:0] imem_address, imem_instruction;
    logic        redirect_valid, id_ready;
    logic [31:0] redirect_target;
    logic        if_id_valid, fetch_fault;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fault_addr, stall_count;

    logic [31:0] mem [256];
    assign imem_instruction = (imem_address < 32'd1024) ? mem[imem_address[9:2]] : 32'hDEAD_BEEF;

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_address(imem_address), .imem_instruction(imem_instruction),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .id_ready(id_ready),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
        .fetch_fault(fetch_fault), .fault_addr(fault_addr),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: the fetch rules applied to plain variables.
    bit          m_boot, m_flt, m_v;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_faddr, m_stall;

    function automatic bit bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    task automatic model_reset();
        m_boot = 1; m_flt = 0; m_v = 0; m_pc = 0; m_instr = NOP;
        m_ipc = 0; m_ipc4 = 0; m_faddr = 0; m_stall = 0;
    endtask

    task automatic model_edge(input bit rv, input logic [31:0] tgt, input bit rdy);
        if (m_flt) return;
        if (m_boot) begin
            m_boot = 0;
            if (bad(m_pc)) begin m_flt = 1; m_faddr = m_pc; end
            return;
        end
        if (rv) begin
            m_v = 0; m_instr = NOP;
            if (bad(tgt)) begin m_flt = 1; m_faddr = tgt; end
            else m_pc = tgt;
        end else if (bad(m_pc)) begin
            m_flt = 1; m_faddr = m_pc; m_v = 0; m_instr = NOP;
        end else if (!m_v || rdy) begin
            m_v = 1; m_instr = mem[m_pc[9:2]]; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_pc = m_pc + 4;
        end else if (m_stall != 32'hFFFF_FFFF) begin
            m_stall++;
        end
    endtask

    task automatic check_model(input int cyc);
        string t;
        t = $sformatf("rand%0d", cyc);
        chk({t, ".addr"},   imem_address,   m_pc);
        chk({t, ".valid"},  32'(if_id_valid), 32'(m_v));
        chk({t, ".instr"},  if_id_instr,    m_instr);
        chk({t, ".pc"},     if_id_pc,       m_ipc);
        chk({t, ".pc4"},    if_id_pc_plus4, m_ipc4);
        chk({t, ".fault"},  32'(fetch_fault), 32'(m_flt));
        chk({t, ".faddr"},  fault_addr,     m_faddr);
        chk({t, ".stall"},  stall_count,    m_stall);
    endtask

    // Reset is asserted between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_addr"},  imem_address,   32'h0);
        chk({tag, ".rst_valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, ".rst_instr"}, if_id_instr,    NOP);
        chk({tag, ".rst_pc"},    if_id_pc,       32'h0);
        chk({tag, ".rst_pc4"},   if_id_pc_plus4, 32'h0);
        chk({tag, ".rst_fault"}, 32'(fetch_fault), 32'h0);
        chk({tag, ".rst_faddr"}, fault_addr,     32'h0);
        chk({tag, ".rst_stall"}, stall_count,    32'h0);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input bit rv, input logic [31:0] tgt, input bit rdy);
        redirect_valid  = rv;
        redirect_target = tgt;
        id_ready        = rdy;
        @(posedge clk);
        model_edge(rv, tgt, rdy);
        #1;
    endtask

    typedef struct {
        bit          rst;
        bit          rv;
        logic [31:0] tgt;
        bit          rdy;
        bit          e_v;
        logic [31:0] e_instr, e_ipc, e_ipc4, e_addr, e_stall;
        bit          e_flt;
        logic [31:0] e_faddr;
    } vec_t;

    vec_t tbl[19];

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0; id_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = W + 32'(i);

        //          rst rv tgt     rdy  v  instr     ipc     ipc4    addr    stall flt faddr
        tbl[0]  = '{0, 0, 0,       1,   0, NOP,      0,      0,      0,      0,    0,  0};
        tbl[1]  = '{0, 0, 0,       1,   1, W+0,      0,      4,      4,      0,    0,  0};
        tbl[2]  = '{0, 0, 0,       1,   1, W+1,      4,      8,      8,      0,    0,  0};
        tbl[3]  = '{0, 0, 0,       1,   1, W+2,      8,      'hC,    'hC,    0,    0,  0};
        tbl[4]  = '{0, 0, 0,       0,   1, W+2,      8,      'hC,    'hC,    1,    0,  0};
        tbl[5]  = '{0, 0, 0,       0,   1, W+2,      8,      'hC,    'hC,    2,    0,  0};
        tbl[6]  = '{0, 0, 0,       0,   1, W+2,      8,      'hC,    'hC,    3,    0,  0};
        tbl[7]  = '{0, 0, 0,       1,   1, W+3,      'hC,    'h10,   'h10,   3,    0,  0};
        tbl[8]  = '{0, 0, 0,       0,   1, W+3,      'hC,    'h10,   'h10,   4,    0,  0};
        tbl[9]  = '{0, 1, 'h28,    0,   0, NOP,      'hC,    'h10,   'h28,   4,    0,  0};
        tbl[10] = '{0, 0, 0,       0,   1, W+10,     'h28,   'h2C,   'h2C,   4,    0,  0};
        tbl[11] = '{0, 1, 'h3FC,   1,   0, NOP,      'h28,   'h2C,   'h3FC,  4,    0,  0};
        tbl[12] = '{0, 0, 0,       1,   1, W+255,    'h3FC,  'h400,  'h400,  4,    0,  0};
        tbl[13] = '{0, 0, 0,       1,   0, NOP,      'h3FC,  'h400,  'h400,  4,    1,  'h400};
        tbl[14] = '{0, 1, 0,       1,   0, NOP,      'h3FC,  'h400,  'h400,  4,    1,  'h400};
        tbl[15] = '{1, 0, 0,       1,   0, NOP,      0,      0,      0,      0,    0,  0};
        tbl[16] = '{0, 0, 0,       1,   1, W+0,      0,      4,      4,      0,    0,  0};
        tbl[17] = '{0, 1, 2,       1,   0, NOP,      0,      4,      4,      0,    1,  2};
        tbl[18] = '{0, 1, 0,       1,   0, NOP,      0,      4,      4,      0,    1,  2};

        @(posedge clk); #1;
        do_reset("init");
        for (int i = 0; i < 19; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            if (tbl[i].rst) do_reset(t);
            step(tbl[i].rv, tbl[i].tgt, tbl[i].rdy);
            chk({t, ".valid"}, 32'(if_id_valid), 32'(tbl[i].e_v));
            chk({t, ".instr"}, if_id_instr,    tbl[i].e_instr);
            chk({t, ".pc"},    if_id_pc,       tbl[i].e_ipc);
            chk({t, ".pc4"},   if_id_pc_plus4, tbl[i].e_ipc4);
            chk({t, ".addr"},  imem_address,   tbl[i].e_addr);
            chk({t, ".stall"}, stall_count,    tbl[i].e_stall);
            chk({t, ".fault"}, 32'(fetch_fault), 32'(tbl[i].e_flt));
            chk({t, ".faddr"}, fault_addr,     tbl[i].e_faddr);
        end

        // Async reset landing mid-stall with a valid entry and a nonzero count.
        do_reset("pre_stall");
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("stall.count", stall_count, 32'd2);
        chk("stall.pc",    if_id_pc,    32'h8);
        do_reset("mid_stall");

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        do_reset("rand_start");
        begin
            int flt_cycles = 0;
            for (int c = 0; c < 3000; c++) begin
                bit          rv, rdy;
                logic [31:0] tgt;
                int          r;
                if (m_flt) flt_cycles++;
                if ($urandom_range(0, 299) == 0 || flt_cycles > 6) begin
                    do_reset($sformatf("rand_rst%0d", c));
                    flt_cycles = 0;
                end
                rv  = ($urandom_range(0, 5) == 0);
                rdy = ($urandom_range(0, 2) != 0);
                r   = $urandom_range(0, 39);
                if (r == 0)      tgt = $urandom;
                else if (r == 1) tgt = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
                else if (r < 5)  tgt = 32'h3F0 + 32'($urandom_range(0, 3) * 4);
                else             tgt = 32'($urandom_range(0, 255) * 4);
                step(rv, tgt, rdy);
                check_model(c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage sitting directly upstream of instruction_memory. Holds the program counter and drives the memory's word address. Captures the combinationally returned instruction into an IF/ID register, offered to decode via a valid/ready handshake. Handles branch/jump redirects from execute, decode backpressure, and misaligned/out-of-range fetch faults.

Parameters:
DATA_WIDTH, 32, instruction width; must match instruction_memory.
ADDRESS_WIDTH, 32, PC and address width.
MEM_SIZE, 256, number of instruction words; legal PCs are 0 .. MEM_SIZE*4-4.
RESET_VECTOR, 32'h0000_0000, PC value after reset; must be word aligned.
NOP_INSTR, 32'h0000_0013, value held in if_id_instr when not valid.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous reset, active low.
imem_address  out  ADDRESS_WIDTH  to instruction_memory.address; always equals pc.
imem_instruction  in  DATA_WIDTH  from instruction_memory.instruction; combinational, same cycle.
redirect_valid  in  1  execute requests a PC change this cycle.
redirect_target  in  ADDRESS_WIDTH  new PC when redirect_valid=1.
id_ready  in  1  decode accepts the IF/ID entry this cycle.
if_id_valid  out  1  IF/ID entry holds a valid instruction.
if_id_instr  out  DATA_WIDTH  fetched instruction.
if_id_pc  out  ADDRESS_WIDTH  address of if_id_instr.
if_id_pc_plus4  out  ADDRESS_WIDTH  if_id_pc+4.
fetch_fault  out  1  sticky; fetch halted on a bad address.
fault_addr  out  ADDRESS_WIDTH  offending address, valid when fetch_fault=1.
stall_count  out  32  cycles in RUN with if_id_valid=1 and id_ready=0.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=BOOT, pc=RESET_VECTOR, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, fetch_fault=0, fault_addr=0, stall_count=0.
- imem_address=pc in every state. The memory read is combinational, so a fetch costs 0 cycles and the IF/ID capture gives 1 cycle latency.
- States: BOOT, RUN, FAULT.
- BOOT: no capture. Next state is RUN unconditionally, or FAULT if the pc check fails.
- pc check: "bad" means pc[1:0]!=0 or pc >= MEM_SIZE*4, compared unsigned at full width.
- RUN, evaluated in priority order each edge:
  1. redirect_valid=1: if_id_valid<=0 (flush, even if id_ready=1). If the target is bad, go to FAULT with fault_addr<=target and pc unchanged. Otherwise pc<=target, with no capture this cycle.
  2. pc is bad: go to FAULT, fault_addr<=pc, if_id_valid<=0.
  3. Advance when if_id_valid=0 or id_ready=1: capture imem_instruction, pc and pc+4 into IF/ID, set if_id_valid<=1, pc<=pc+4.
  4. Otherwise stall: hold pc and IF/ID, stall_count+=1 (saturating at 2^32-1).
- Handshake: a transfer occurs when if_id_valid and id_ready are both 1. if_id_* must not change while valid=1 and ready=0, except on a redirect flush.
- pc+4 wraps modulo 2^ADDRESS_WIDTH. A wrapped PC is caught by the range check.
- When if_id_valid=0, if_id_instr=NOP_INSTR; if_id_pc and if_id_pc_plus4 hold their last values.
- FAULT is terminal until reset: if_id_valid=0, fetch_fault=1, pc frozen, redirect_valid and id_ready ignored.
- A fault takes effect on the edge it is detected. The entry already in IF/ID at that edge is dropped.
- Reset asserted mid-operation returns everything to reset values immediately. The first capture occurs 2 edges after rst_n rises (BOOT, then RUN).

Decomposition:
- Package fetch_pkg:
  - typedef fetch_state_t enum {BOOT, RUN, FAULT}.
  - NOP_INSTR constant.
  - PC_INCR=4.
  - Function addr_is_bad(addr, mem_size).
- One sub-module, if_id_register: holds the valid/instr/pc/pc_plus4 pipeline register with load, flush and hold controls, reused by later stage registers.
- The PC register and FSM stay in the top level.

Test Plan:
- Reset and sequential fetch: release rst_n with id_ready=1 and memory preloaded with word i = 0x1000_0000+i. Required: imem_address 0x0, 0x4, 0x8…; first if_id_valid=1 on the 2nd edge with instr 0x1000_0000 and pc 0x0; then 0x1000_0001 at pc 0x4, and so on.
- Backpressure: hold id_ready=0 for 3 cycles while valid with pc 0x8. Required: if_id_pc stays 0x8, imem_address stays 0xC, stall_count=3; on release, the next entry is pc 0xC.
- Redirect: redirect_valid=1 with target 0x28 while IF/ID is valid and stalled. Required: if_id_valid=0 the next cycle; the next entry is pc 0x28, instr word 10, pc_plus4 0x2C.
- Misaligned redirect: target 0x0000_0002. Required: fetch_fault=1, fault_addr=0x2, if_id_valid stays 0, pc unchanged; later redirects to 0x0 are ignored.
- Range end: redirect to 0x3FC with id_ready=1. Required: the entry at pc 0x3FC is delivered, then FAULT with fault_addr=0x400.
- Async reset mid-stall, asserted between clock edges. Required: all outputs return to reset values immediately, without waiting for a clock edge.
